// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer around a single-bit bitwise/compare slice: accepts an
// operand pair, walks the slice LSB first, and returns the word plus chain flag.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             slice_op1,
  output logic             slice_op0,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  input  logic             slice_q,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_flag
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic [1:0]       op;
  logic             carry;
  logic [WIDTH-1:0] res_next;

  assign res_next = {slice_q, res[WIDTH-1:1]};

  // Operand shifters drain to zero by DONE, so the slice inputs idle low
  // without extra gating; carry is cleared on the last RUN edge for the same reason.
  assign slice_a   = a_sh[0];
  assign slice_b   = b_sh[0];
  assign slice_cin = carry;
  assign slice_op1 = op[1];
  assign slice_op0 = op[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      cnt       <= '0;
      op        <= 2'b00;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= in_a;
            b_sh     <= in_b;
            op       <= in_op;
            carry    <= 1'b0;
            cnt      <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          carry <= slice_cout;
          // Final bit: capture word and flag, apply deferred inversion for op0.
          if (cnt == CW'(WIDTH - 1)) begin
            carry     <= 1'b0;
            out_q     <= res_next;
            out_flag  <= slice_cout ^ op[0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: behavioural slice, word-level scoreboard model,
// latency/backpressure/reset checks.
module tb_alu_serial_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         slice_op1, slice_op0, slice_a, slice_b, slice_cin;
  logic         slice_q, slice_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic         out_flag;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .slice_op1(slice_op1), .slice_op0(slice_op0), .slice_a(slice_a), .slice_b(slice_b),
    .slice_cin(slice_cin), .slice_q(slice_q), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_flag(out_flag)
  );

  // Single-bit slice: bitwise result plus ne chain (op1=0) or LSB-first lt chain (op1=1).
  always_comb begin
    case ({slice_op1, slice_op0})
      2'b00:   slice_q = 1'b0;
      2'b01:   slice_q = slice_a ^ slice_b;
      2'b10:   slice_q = slice_a & slice_b;
      default: slice_q = slice_a | slice_b;
    endcase
    if (slice_op1)
      slice_cout = (~slice_a & slice_b) | (~(slice_a ^ slice_b) & slice_cin);
    else
      slice_cout = slice_cin | (slice_a ^ slice_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [W-1:0] q;
    logic         chain;
    case (op)
      2'b00:   q = '0;
      2'b01:   q = a ^ b;
      2'b10:   q = a & b;
      default: q = a | b;
    endcase
    chain = op[1] ? (a < b) : (a != b);
    return {q, chain ^ op[0]};
  endfunction

  // Drive one request, follow the slice each RUN cycle, then check the result.
  task automatic run_txn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
    logic       exp_cin;
    logic       last_cout;
    logic [W:0] exp;
    logic [W-1:0] q0;
    logic       f0;
    int         lat;
    sb.push_back(model(op, a, b));
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_op     = 2'($urandom);
    in_a      = W'($urandom);
    in_b      = W'($urandom);
    exp_cin   = 1'b0;
    last_cout = 1'b0;
    lat       = 0;
    while (!out_valid && lat < W + 4) begin
      check("slice_cin", 32'(slice_cin), 32'(exp_cin));
      if (lat < W) begin
        check("slice_a", 32'(slice_a), 32'(a[lat]));
        check("slice_b", 32'(slice_b), 32'(b[lat]));
      end
      exp_cin   = slice_cout;
      last_cout = slice_cout;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(W));
    check("done_in_ready", 32'(in_ready), 32'd0);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    check("out_q", 32'(out_q), 32'(exp[W:1]));
    check("out_flag", 32'(out_flag), 32'(exp[0]));
    check("flag_vs_cout", 32'(out_flag), 32'(last_cout ^ op[0]));
    q0 = out_q;
    f0 = out_flag;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_q", 32'(out_q), 32'(q0));
      check("hold_flag", 32'(out_flag), 32'(f0));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_q", 32'(out_q), 32'd0);
    check("rst_out_flag", 32'(out_flag), 32'd0);
    check("rst_slice", 32'({slice_a, slice_b, slice_cin, slice_op1, slice_op0}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(2'b01, 8'h5A, 8'h0F, 0);
    run_txn(2'b10, 8'hF0, 8'h3C, 0);
    run_txn(2'b11, 8'hF0, 8'h3C, 0);
    run_txn(2'b00, 8'hA5, 8'hA5, 0);
    run_txn(2'b00, 8'h01, 8'h00, 0);
    run_txn(2'b10, 8'h3C, 8'hF0, 0);
    run_txn(2'b01, 8'h81, 8'h7E, 5);

    // Reset on the third RUN cycle discards the transaction.
    in_valid = 1'b1;
    in_op    = 2'b11;
    in_a     = 8'h12;
    in_b     = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    check("mid_rst_op", 32'({slice_op1, slice_op0}), 32'd0);
    rst_n = 1'b1;
    repeat (W + 2) @(posedge clk);
    #1;
    check("mid_rst_no_out", 32'(out_valid), 32'd0);

    run_txn(2'b11, 8'h12, 8'h34, 0);
    for (int k = 0; k < 4; k++)
      run_txn(2'($urandom), W'($urandom), W'($urandom), k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that sits directly upstream and downstream of the single-bit bitwise/compare slice. It accepts a WIDTH-bit operand pair and a 2-bit op over a ready/valid handshake. It then drives the slice one bit per clock, LSB first, ripples the slice carry through a register, and assembles the result word. It applies the deferred flag inversion for op0=1 and presents result and flag over a second ready/valid handshake.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk edge.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request (high only in IDLE).
- in_op  in  2  {op1,op0}: 00 = zero/ne chain, 01 = xor/ne chain, 10 = and/lt chain, 11 = or/lt chain.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- slice_op1, slice_op0  out  1 each  op bits to slice.
- slice_a, slice_b  out  1 each  current operand bits to slice.
- slice_cin  out  1  registered carry to slice.
- slice_q  in  1  slice result bit (combinational from slice_* outputs).
- slice_cout  in  1  slice carry out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_q  out  WIDTH  result word.
- out_flag  out  1  final chain flag, after inversion.

## Operation
- States: IDLE, RUN, DONE. All registers are cleared by reset.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_sh=in_a, b_sh=in_b, op=in_op. Clear carry=0, cnt=0, res=0. Go to RUN.
- RUN:
  - Drive slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry, slice_op1/0=op.
  - Each edge:
    - res <= {slice_q, res[WIDTH-1:1]}.
    - carry <= slice_cout.
    - a_sh and b_sh shift right by 1.
    - cnt++.
  - On the edge where cnt==WIDTH-1, go to DONE. Exactly WIDTH bits are processed.
- DONE:
  - out_valid=1, out_q=res, out_flag=carry XOR op[0].
  - in_ready=0.
  - On out_ready, go to IDLE.
- slice_a, slice_b and slice_cin are 0 outside RUN. slice_op1/0 always reflect the latched op.
- in_a, in_b and in_op are don't-care except on the accept edge. Changes during RUN or DONE have no effect.
- cnt width is ceil(log2(WIDTH)); it wraps only via reset or re-accept.
- out_q and out_flag are registered and hold stable throughout DONE.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, out_q=0, out_flag=0, slice_a/b/cin=0, slice_op=00. These values hold from the first edge with rst_n=0.
- Reset asserted in any state wins over every other event. A RUN or DONE transaction in progress is discarded and produces no out_valid.
- Accept edge: the edge with state=IDLE and in_valid=1.
- Latency: out_valid rises WIDTH edges after the accept edge.
- A transfer completes on the edge with out_valid=1 and out_ready=1.
- No new request is accepted on the completion edge. in_ready rises the cycle after.
- Minimum initiation interval is WIDTH+2 cycles.
- out_ready already high on DONE entry: DONE lasts exactly one cycle.
- out_ready low: DONE holds indefinitely with outputs stable.
- in_valid held high in DONE is ignored until IDLE.
- The slice path is combinational. slice_q and slice_cout are sampled the same cycle slice_* are driven.

## Test plan
- WIDTH=8, op=01, a=0x5A, b=0x0F, out_ready=1:
  - out_q=0x55, out_flag=0 (chain 1, inverted).
  - out_valid exactly 8 edges after accept, high 1 cycle.
- op=10, a=0xF0, b=0x3C:
  - out_q=0x30.
- op=11 with the same operands:
  - out_q=0xFC.
  - out_flag equals the final slice_cout inverted.
  - Bench checks slice_cin each cycle equals the previous slice_cout.
- op=00:
  - a=b=0xA5: out_q=0x00, out_flag=0.
  - a=0x01, b=0x00: out_flag=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_q and out_flag remain stable, in_ready=0.
  - in_valid pulses are ignored.
  - Release out_ready: one transfer, then in_ready=1 the next cycle.
- Reset: assert rst_n=0 on cycle 3 of RUN.
  - Next cycle: state IDLE, out_valid=0, in_ready=1, slice_a/b/cin=0.
  - A fresh request then completes normally with correct result.
